// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the ctrl_seq instruction sequencer and its output decoder.
package ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_HALT   = 3'd4
    } state_t;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_XOR  = 4'h4;
    localparam logic [3:0] OP_NOT  = 4'h5;
    localparam logic [3:0] OP_SHL  = 4'h6;
    localparam logic [3:0] OP_SHR  = 4'h7;
    localparam logic [3:0] OP_LDI  = 4'h8;
    localparam logic [3:0] OP_MOV  = 4'h9;
    localparam logic [3:0] OP_JMP  = 4'hA;
    localparam logic [3:0] OP_JZ   = 4'hB;
    localparam logic [3:0] OP_JC   = 4'hC;
    localparam logic [3:0] OP_CALL = 4'hD;
    localparam logic [3:0] OP_RET  = 4'hE;
    localparam logic [3:0] OP_HLT  = 4'hF;

    // {S11,S10} PC source
    localparam logic [1:0] PC_SRC_INC = 2'b00;
    localparam logic [1:0] PC_SRC_BR  = 2'b01;
    localparam logic [1:0] PC_SRC_STK = 2'b10;

    // rw stack-pointer operation
    localparam logic [1:0] SP_IDLE = 2'b00;
    localparam logic [1:0] SP_PUSH = 2'b01;
    localparam logic [1:0] SP_POP  = 2'b10;

    // enab register-file operation
    localparam logic [1:0] RF_IDLE  = 2'b00;
    localparam logic [1:0] RF_WRITE = 2'b01;
    localparam logic [1:0] RF_READ  = 2'b10;

    // mux_sel write-back source
    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_IMM = 2'b01;
    localparam logic [1:0] WB_REG = 2'b10;

    // The eight ALU opcodes occupy the lower half of the opcode space.
    function automatic logic is_alu_op(input logic [3:0] op);
        return ~op[3];
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational control-word decode from FSM state and the captured opcode/fields.
// CALL/RET stack handling is enabled by defining CTRL_SEQ_STACK_EN; otherwise they decode as NOP.
module ctrl_decode
    import ctrl_pkg::*;
(
    input  state_t      state,
    input  logic [9:0]  ir_q,
    input  logic        mem_ready,
    input  logic        flag_z,
    input  logic        flag_c,
    output logic        L_IR,
    output logic        I_PC,
    output logic        L_PC,
    output logic        S11,
    output logic        S10,
    output logic [1:0]  rw,
    output logic [1:0]  enab,
    output logic [2:0]  reg_sel,
    output logic [1:0]  mux_sel,
    output logic [3:0]  S_AF,
    output logic        S_AL,
    output logic        sel_a,
    output logic        sel_b,
    output logic        halted
);

    logic [3:0] w_op;
    logic [2:0] w_rd;
    logic [2:0] w_rs;
    logic [1:0] w_pc_src;

    assign w_op = ir_q[9:6];
    assign w_rd = ir_q[5:3];
    assign w_rs = ir_q[2:0];
    assign S11  = w_pc_src[1];
    assign S10  = w_pc_src[0];

    always_comb begin
        // NOTE: every output gets a default first, so no path through the case infers a latch.
        L_IR     = 1'b0;
        I_PC     = 1'b0;
        L_PC     = 1'b0;
        w_pc_src = PC_SRC_INC;
        rw       = SP_IDLE;
        enab     = RF_IDLE;
        reg_sel  = 3'd0;
        mux_sel  = WB_ALU;
        S_AF     = 4'd0;
        S_AL     = 1'b0;
        sel_a    = 1'b0;
        sel_b    = 1'b0;
        halted   = 1'b0;

        case (state)
            ST_FETCH: begin
                L_IR = mem_ready;
                I_PC = mem_ready;
            end
            ST_DECODE: begin
                enab    = RF_READ;
                reg_sel = w_rs;
            end
            ST_EXEC: begin
                if (is_alu_op(w_op)) begin
                    S_AF    = w_op;
                    sel_a   = 1'b1;
                    sel_b   = 1'b1;
                    S_AL    = 1'b1;
                    enab    = RF_WRITE;
                    reg_sel = w_rd;
                    mux_sel = WB_ALU;
                end else begin
                    case (w_op)
                        OP_LDI: begin
                            enab    = RF_WRITE;
                            reg_sel = w_rd;
                            mux_sel = WB_IMM;
                        end
                        OP_MOV: begin
                            enab    = RF_WRITE;
                            reg_sel = w_rd;
                            mux_sel = WB_REG;
                        end
                        OP_JMP: begin
                            L_PC     = 1'b1;
                            w_pc_src = PC_SRC_BR;
                        end
                        OP_JZ: if (flag_z) begin
                            L_PC     = 1'b1;
                            w_pc_src = PC_SRC_BR;
                        end
                        OP_JC: if (flag_c) begin
                            L_PC     = 1'b1;
                            w_pc_src = PC_SRC_BR;
                        end
`ifdef CTRL_SEQ_STACK_EN
                        OP_CALL: begin
                            rw       = SP_PUSH;
                            L_PC     = 1'b1;
                            w_pc_src = PC_SRC_BR;
                        end
                        OP_RET: begin
                            rw       = SP_POP;
                            L_PC     = 1'b1;
                            w_pc_src = PC_SRC_STK;
                        end
`endif
                        default: ;
                    endcase
                end
            end
            ST_HALT: halted = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/ctrl_seq.sv
// Fetch/decode/execute sequencer: state register and captured instruction fields.
// Optional CALL/RET stack support via CTRL_SEQ_STACK_EN (see ctrl_decode).
module ctrl_seq
    import ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        mem_ready,
    input  logic [15:0] instr,
    input  logic        flag_z,
    input  logic        flag_c,
    output logic        L_IR,
    output logic        I_PC,
    output logic        L_PC,
    output logic        S11,
    output logic        S10,
    output logic [1:0]  rw,
    output logic [1:0]  enab,
    output logic [2:0]  reg_sel,
    output logic [1:0]  mux_sel,
    output logic [3:0]  S_AF,
    output logic        S_AL,
    output logic        sel_a,
    output logic        sel_b,
    output logic        halted
);

    state_t     r_state;
    logic [9:0] ir_q;

    // Immediate bits are consumed by the datapath, not by the sequencer.
    logic w_unused_imm;
    assign w_unused_imm = ^instr[5:0];

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            r_state <= ST_IDLE;
            ir_q    <= '0;
        end else begin
            case (r_state)
                ST_IDLE:   if (start) r_state <= ST_FETCH;
                ST_FETCH:  if (mem_ready) begin
                    ir_q    <= instr[15:6];
                    r_state <= ST_DECODE;
                end
                ST_DECODE: r_state <= ST_EXEC;
                ST_EXEC:   r_state <= (ir_q[9:6] == OP_HLT) ? ST_HALT : ST_FETCH;
                ST_HALT:   r_state <= ST_HALT;
                default:   r_state <= ST_IDLE;
            endcase
        end
    end

    ctrl_decode u_decode (
        .state     (r_state),
        .ir_q      (ir_q),
        .mem_ready (mem_ready),
        .flag_z    (flag_z),
        .flag_c    (flag_c),
        .L_IR      (L_IR),
        .I_PC      (I_PC),
        .L_PC      (L_PC),
        .S11       (S11),
        .S10       (S10),
        .rw        (rw),
        .enab      (enab),
        .reg_sel   (reg_sel),
        .mux_sel   (mux_sel),
        .S_AF      (S_AF),
        .S_AL      (S_AL),
        .sel_a     (sel_a),
        .sel_b     (sel_b),
        .halted    (halted)
    );

endmodule

// File: tb/tb_ctrl_seq.sv
// Scoreboard bench for ctrl_seq: stimulus queues hand-computed control words, a monitor compares them.
module tb_ctrl_seq;

    typedef struct packed {
        logic       l_ir;
        logic       i_pc;
        logic       l_pc;
        logic       s11;
        logic       s10;
        logic [1:0] rw;
        logic [1:0] enab;
        logic [2:0] reg_sel;
        logic [1:0] mux_sel;
        logic [3:0] s_af;
        logic       s_al;
        logic       sel_a;
        logic       sel_b;
        logic       halted;
    } outv_t;

    typedef struct {
        int    cyc;
        int    ph;
        outv_t exp;
        string name;
    } sb_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        mem_ready = 1'b0;
    logic [15:0] instr = 16'h0000;
    logic        flag_z = 1'b0;
    logic        flag_c = 1'b0;

    logic       L_IR, I_PC, L_PC, S11, S10, S_AL, sel_a, sel_b, halted;
    logic [1:0] rw, enab, mux_sel;
    logic [2:0] reg_sel;
    logic [3:0] S_AF;

    outv_t act;
    assign act = {L_IR, I_PC, L_PC, S11, S10, rw, enab, reg_sel, mux_sel, S_AF, S_AL, sel_a, sel_b, halted};

    sb_t  sb_q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    event rst_probe;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ctrl_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .mem_ready (mem_ready),
        .instr     (instr),
        .flag_z    (flag_z),
        .flag_c    (flag_c),
        .L_IR      (L_IR),
        .I_PC      (I_PC),
        .L_PC      (L_PC),
        .S11       (S11),
        .S10       (S10),
        .rw        (rw),
        .enab      (enab),
        .reg_sel   (reg_sel),
        .mux_sel   (mux_sel),
        .S_AF      (S_AF),
        .S_AL      (S_AL),
        .sel_a     (sel_a),
        .sel_b     (sel_b),
        .halted    (halted)
    );

    // Expected control words
    function automatic outv_t e_idle();
        return '0;
    endfunction

    function automatic outv_t e_fetch();
        outv_t e = '0;
        e.l_ir = 1'b1;
        e.i_pc = 1'b1;
        return e;
    endfunction

    function automatic outv_t e_dec(input logic [2:0] rs);
        outv_t e = '0;
        e.enab    = 2'b10;
        e.reg_sel = rs;
        return e;
    endfunction

    function automatic outv_t e_alu(input logic [3:0] op, input logic [2:0] rd);
        outv_t e = '0;
        e.s_af    = op;
        e.sel_a   = 1'b1;
        e.sel_b   = 1'b1;
        e.s_al    = 1'b1;
        e.enab    = 2'b01;
        e.reg_sel = rd;
        return e;
    endfunction

    function automatic outv_t e_wr(input logic [2:0] rd, input logic [1:0] mux);
        outv_t e = '0;
        e.enab    = 2'b01;
        e.reg_sel = rd;
        e.mux_sel = mux;
        return e;
    endfunction

    function automatic outv_t e_jump(input logic [1:0] rwop, input logic [1:0] src);
        outv_t e = '0;
        e.l_pc = 1'b1;
        e.s11  = src[1];
        e.s10  = src[0];
        e.rw   = rwop;
        return e;
    endfunction

    function automatic outv_t e_halt();
        outv_t e = '0;
        e.halted = 1'b1;
        return e;
    endfunction

    task automatic push_exp(input int ph, input outv_t e, input string nm);
        sb_t t;
        t.cyc  = cyc;
        t.ph   = ph;
        t.exp  = e;
        t.name = nm;
        sb_q.push_back(t);
    endtask

    // Drive one cycle of inputs just after the edge and queue the control word expected for it.
    task automatic tick(input logic rn, input logic s, input logic mr, input logic [15:0] ins,
                        input logic fz, input logic fc, input outv_t e, input string nm);
        @(posedge clk);
        #1;
        rst_n     = rn;
        start     = s;
        mem_ready = mr;
        instr     = ins;
        flag_z    = fz;
        flag_c    = fc;
        push_exp(0, e, nm);
    endtask

    task automatic sample(input int ph);
        checks++;
        if (L_PC && I_PC) begin
            errors++;
            $display("FAIL pc_exclusive cyc=%0d: L_PC=%b I_PC=%b, required not both 1", cyc, L_PC, I_PC);
        end
        while (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
            errors++;
            $display("FAIL %s: expectation for cyc=%0d never sampled", sb_q[0].name, sb_q[0].cyc);
            void'(sb_q.pop_front());
        end
        while (sb_q.size() > 0 && sb_q[0].cyc == cyc && sb_q[0].ph == ph) begin
            checks++;
            if (act !== sb_q[0].exp) begin
                errors++;
                $display("FAIL %s cyc=%0d: got %06h required %06h", sb_q[0].name, cyc, act, sb_q[0].exp);
            end
            void'(sb_q.pop_front());
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            #1;
            sample(0);
        end
    end

    initial begin
        forever begin
            @(rst_probe);
            #1;
            sample(1);
        end
    end

    initial begin
        // Reset and idle behaviour
        tick(0, 1, 1, 16'h0A40, 0, 0, e_idle(),  "reset_start_ignored");
        tick(0, 0, 0, 16'h0000, 0, 0, e_idle(),  "reset_hold");
        tick(1, 0, 1, 16'h0A40, 0, 0, e_idle(),  "idle_no_start");
        tick(1, 0, 0, 16'h0000, 0, 0, e_idle(),  "idle_wait");
        tick(1, 1, 1, 16'h0A40, 0, 0, e_idle(),  "idle_start");
        // ADD rd=5 rs=1
        tick(1, 0, 1, 16'h0A40, 0, 0, e_fetch(), "add_fetch");
        tick(1, 0, 0, 16'h0000, 0, 0, e_dec(3'd1), "add_decode");
        tick(1, 0, 0, 16'h0000, 0, 0, e_alu(4'h0, 3'd5), "add_exec");
        // Fetch stall, start ignored outside IDLE
        tick(1, 1, 0, 16'h0000, 0, 0, e_idle(),  "stall0");
        tick(1, 0, 0, 16'h0000, 0, 0, e_idle(),  "stall1");
        tick(1, 0, 0, 16'h0000, 0, 0, e_idle(),  "stall2");
        tick(1, 0, 0, 16'h0000, 0, 0, e_idle(),  "stall3");
        // LDI rd=3
        tick(1, 0, 1, 16'h8600, 0, 0, e_fetch(), "ldi_fetch");
        tick(1, 0, 0, 16'h0000, 0, 0, e_dec(3'd0), "ldi_decode");
        tick(1, 0, 0, 16'h0000, 0, 0, e_wr(3'd3, 2'b01), "ldi_exec");
        // MOV rd=2 rs=6
        tick(1, 0, 1, 16'h9580, 0, 0, e_fetch(), "mov_fetch");
        tick(1, 0, 0, 16'h0000, 0, 0, e_dec(3'd6), "mov_decode");
        tick(1, 0, 0, 16'h0000, 0, 0, e_wr(3'd2, 2'b10), "mov_exec");
        // XOR rd=7 rs=2
        tick(1, 0, 1, 16'h4E80, 0, 0, e_fetch(), "xor_fetch");
        tick(1, 0, 0, 16'h0000, 0, 0, e_dec(3'd2), "xor_decode");
        tick(1, 0, 0, 16'h0000, 0, 0, e_alu(4'h4, 3'd7), "xor_exec");
        // JZ taken, then untaken with flags flipped between DECODE and EXEC
        tick(1, 0, 1, 16'hB000, 0, 0, e_fetch(), "jz_fetch");
        tick(1, 0, 0, 16'h0000, 0, 0, e_dec(3'd0), "jz_decode");
        tick(1, 0, 0, 16'h0000, 1, 0, e_jump(2'b00, 2'b01), "jz_taken");
        tick(1, 0, 1, 16'hB000, 1, 0, e_fetch(), "jz2_fetch");
        tick(1, 0, 0, 16'h0000, 1, 0, e_dec(3'd0), "jz2_decode");
        tick(1, 0, 0, 16'h0000, 0, 1, e_idle(),  "jz_not_taken");
        // JC taken and untaken
        tick(1, 0, 1, 16'hC000, 0, 0, e_fetch(), "jc_fetch");
        tick(1, 0, 0, 16'h0000, 0, 0, e_dec(3'd0), "jc_decode");
        tick(1, 0, 0, 16'h0000, 0, 1, e_jump(2'b00, 2'b01), "jc_taken");
        tick(1, 0, 1, 16'hC000, 0, 0, e_fetch(), "jc2_fetch");
        tick(1, 0, 0, 16'h0000, 0, 1, e_dec(3'd0), "jc2_decode");
        tick(1, 0, 0, 16'h0000, 1, 0, e_idle(),  "jc_not_taken");
        // JMP
        tick(1, 0, 1, 16'hA000, 0, 0, e_fetch(), "jmp_fetch");
        tick(1, 0, 0, 16'h0000, 0, 0, e_dec(3'd0), "jmp_decode");
        tick(1, 0, 0, 16'h0000, 0, 0, e_jump(2'b00, 2'b01), "jmp_exec");
        // CALL / RET
        tick(1, 0, 1, 16'hD000, 0, 0, e_fetch(), "call_fetch");
        tick(1, 0, 0, 16'h0000, 0, 0, e_dec(3'd0), "call_decode");
`ifdef CTRL_SEQ_STACK_EN
        tick(1, 0, 0, 16'h0000, 0, 0, e_jump(2'b01, 2'b01), "call_exec");
`else
        tick(1, 0, 0, 16'h0000, 0, 0, e_idle(),  "call_exec_nop");
`endif
        tick(1, 0, 1, 16'hE000, 0, 0, e_fetch(), "ret_fetch");
        tick(1, 0, 0, 16'h0000, 0, 0, e_dec(3'd0), "ret_decode");
`ifdef CTRL_SEQ_STACK_EN
        tick(1, 0, 0, 16'h0000, 0, 0, e_jump(2'b10, 2'b10), "ret_exec");
`else
        tick(1, 0, 0, 16'h0000, 0, 0, e_idle(),  "ret_exec_nop");
`endif
        // HLT: sticky halt with start pulsed, left only by reset
        tick(1, 0, 1, 16'hF000, 0, 0, e_fetch(), "hlt_fetch");
        tick(1, 0, 0, 16'h0000, 0, 0, e_dec(3'd0), "hlt_decode");
        tick(1, 0, 0, 16'h0000, 0, 0, e_idle(),  "hlt_exec");
        for (int i = 0; i < 10; i++)
            tick(1, i[0], 1, 16'h0A40, 1, 1, e_halt(), $sformatf("halted_%0d", i));
        tick(0, 0, 0, 16'h0000, 0, 0, e_idle(),  "halt_reset");
        tick(1, 0, 0, 16'h0000, 0, 0, e_idle(),  "after_halt_idle");
        // Reset in the middle of an ADD EXEC cycle
        tick(1, 1, 1, 16'h0A40, 0, 0, e_idle(),  "restart");
        tick(1, 0, 1, 16'h0A40, 0, 0, e_fetch(), "add2_fetch");
        tick(1, 0, 0, 16'h0000, 0, 0, e_dec(3'd1), "add2_decode");
        tick(1, 0, 0, 16'h0000, 0, 0, e_alu(4'h0, 3'd5), "add2_exec");
        @(negedge clk);
        #3;
        push_exp(1, e_idle(), "rst_mid_exec");
        rst_n = 1'b0;
        -> rst_probe;
        tick(0, 0, 1, 16'h0A40, 0, 0, e_idle(),  "rst_mid_hold");
        for (int i = 0; i < 3; i++)
            tick(1, 0, 1, 16'h0A40, 0, 0, e_idle(), $sformatf("post_reset_idle_%0d", i));

        @(posedge clk);
        @(negedge clk);
        #3;
        if (sb_q.size() != 0) begin
            errors += sb_q.size();
            $display("FAIL scoreboard_drain: %0d expectations left, required 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
